// File: rtl/relu_backward.sv
// ReLU backward gate: a FIFO of forward sign-mask bits gates upstream gradients.
// One mask bit per forward sample, consumed in order by one gradient beat each.
module relu_backward #(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic [W-1:0]             fwd_in,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic [W-1:0]             grad_in,
  output logic                     dx_valid,
  input  logic                     dx_ready,
  output logic [W-1:0]             dx_out,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mask_q;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dx_valid_q, dx_valid_d;
  logic [W-1:0]     dx_q, dx_d;

  logic push, pop, load;

  assign fwd_ready  = (count_q != CW'(DEPTH));
  assign grad_ready = (count_q != '0) && (!dx_valid_q || dx_ready);
  assign push       = fwd_valid && fwd_ready;
  assign pop        = grad_valid && grad_ready;
  // A flush swallows any handshake landing in the same cycle.
  assign load       = pop && !flush;

  assign dx_valid = dx_valid_q;
  assign dx_out   = dx_q;
  assign count    = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    dx_valid_d = dx_valid_q;
    dx_d       = dx_q;
    if (load) begin
      dx_valid_d = 1'b1;
      dx_d       = mask_q[rptr_q] ? grad_in : '0;
    end else if (dx_ready) begin
      dx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dx_valid_q <= 1'b0;
      dx_q       <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dx_valid_q <= dx_valid_d;
      dx_q       <= dx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mask_q[wptr_q] <= ~fwd_in[W-1];
  end

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward with a queue-based reference model.
// The model is compared against the DUT on every falling edge.
module tb_relu_backward;

  localparam int W     = 17;
  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   fwd_valid = 1'b0;
  logic                   fwd_ready;
  logic [W-1:0]           fwd_in = '0;
  logic                   grad_valid = 1'b0;
  logic                   grad_ready;
  logic [W-1:0]           grad_in = '0;
  logic                   dx_valid;
  logic                   dx_ready = 1'b0;
  logic [W-1:0]           dx_out;
  logic                   flush = 1'b0;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  relu_backward #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_in(fwd_in),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .dx_valid(dx_valid), .dx_ready(dx_ready), .dx_out(dx_out),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of mask bits and one output register.
  bit m_q[$];
  bit m_dxv = 1'b0;
  int m_dx  = 0;
  bit live  = 1'b0;

  always @(posedge clk) begin
    bit mfr, mgr, b;
    if (rst) begin
      m_q.delete();
      m_dxv = 1'b0;
      m_dx  = 0;
      live  = 1'b1;
    end else begin
      mfr = (m_q.size() < DEPTH);
      mgr = (m_q.size() != 0) && (!m_dxv || dx_ready);
      if (flush) begin
        m_q.delete();
        if (m_dxv && dx_ready) m_dxv = 1'b0;
      end else begin
        if (grad_valid && mgr) begin
          b     = m_q.pop_front();
          m_dxv = 1'b1;
          m_dx  = b ? int'($signed(grad_in)) : 0;
        end else if (dx_ready) begin
          m_dxv = 1'b0;
        end
        if (fwd_valid && mfr) m_q.push_back(!fwd_in[W-1]);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m_count", int'(count), m_q.size());
      chk("m_fwd_ready", int'(fwd_ready), int'(m_q.size() < DEPTH));
      chk("m_grad_ready", int'(grad_ready),
          int'((m_q.size() != 0) && (!m_dxv || dx_ready)));
      chk("m_dx_valid", int'(dx_valid), int'(m_dxv));
      chk("m_dx_out", int'($signed(dx_out)), m_dx);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fwd_valid = 1'b0;
    grad_valid = 1'b0;
    flush = 1'b0;
    dx_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int v);
    fwd_valid = 1'b1;
    fwd_in = W'(v);
    step();
    fwd_valid = 1'b0;
  endtask

  initial begin
    int exp4 [4] = '{100, 0, 100, 0};
    int vals [4] = '{12345, -1, 0, -32768};

    // Reset state
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_fwd_ready", int'(fwd_ready), 1);
    chk("rst_grad_ready", int'(grad_ready), 0);
    chk("rst_dx_valid", int'(dx_valid), 0);
    chk("rst_dx_out", int'($signed(dx_out)), 0);

    // Sign gating with edge values
    for (int i = 0; i < 4; i++) push(vals[i]);
    chk("s1_count", int'(count), 4);
    dx_ready = 1'b1;
    grad_valid = 1'b1;
    grad_in = W'(100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s1_dx_valid", int'(dx_valid), 1);
      chk("s1_dx_out", int'($signed(dx_out)), exp4[i]);
      chk("s1_model_dx", m_dx, exp4[i]);
    end
    grad_valid = 1'b0;
    step();
    chk("s1_dx_drop", int'(dx_valid), 0);
    chk("s1_dx_hold", int'($signed(dx_out)), 0);

    // Full FIFO and wrap of write pointer
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i - 8);
    chk("s2_count_full", int'(count), 16);
    chk("s2_fwd_ready", int'(fwd_ready), 0);
    push(77);
    chk("s2_no_17th", int'(count), 16);
    dx_ready = 1'b1;
    grad_valid = 1'b1;
    grad_in = W'(9);
    step();
    grad_valid = 1'b0;
    chk("s2_count_pop", int'(count), 15);
    chk("s2_fwd_ready_back", int'(fwd_ready), 1);
    chk("s2_dx_neg", int'($signed(dx_out)), 0);

    // Backpressure on dx
    do_reset();
    push(1); push(2); push(3);
    dx_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in = W'(50);
    step();
    grad_in = W'(60);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_hold_dx", int'($signed(dx_out)), 50);
      chk("s3_hold_count", int'(count), 2);
      chk("s3_grad_ready", int'(grad_ready), 0);
    end
    dx_ready = 1'b1;
    step();
    chk("s3_beat2", int'($signed(dx_out)), 60);
    grad_in = W'(70);
    step();
    chk("s3_beat3", int'($signed(dx_out)), 70);
    chk("s3_valid3", int'(dx_valid), 1);
    grad_valid = 1'b0;
    step();
    chk("s3_empty", int'(count), 0);

    // Full throughput, both pointers wrapping
    do_reset();
    for (int i = 0; i < 5; i++) push((i % 2) ? -(i + 1) : (i + 1));
    dx_ready = 1'b1;
    fwd_valid = 1'b1;
    grad_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fwd_in = W'((i % 2) ? -(3 * i + 5) : (3 * i + 5));
      grad_in = W'(1000 - 37 * i);
      step();
    end
    fwd_valid = 1'b0;
    grad_valid = 1'b0;
    chk("s4_count", int'(count), 5);

    // Flush colliding with both handshakes
    do_reset();
    for (int i = 0; i < 7; i++) push(i + 1);
    dx_ready = 1'b1;
    flush = 1'b1;
    fwd_valid = 1'b1;
    grad_valid = 1'b1;
    grad_in = W'(11);
    step();
    flush = 1'b0;
    fwd_valid = 1'b0;
    grad_valid = 1'b0;
    chk("s5_count", int'(count), 0);
    chk("s5_grad_ready", int'(grad_ready), 0);
    chk("s5_no_beat", int'(dx_valid), 0);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) push(i + 2);
    dx_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in = W'(33);
    step();
    grad_valid = 1'b0;
    chk("s6_pre_count", int'(count), 4);
    chk("s6_pre_valid", int'(dx_valid), 1);
    do_reset();
    chk("s6_count", int'(count), 0);
    chk("s6_dx_valid", int'(dx_valid), 0);
    chk("s6_dx_out", int'($signed(dx_out)), 0);
    push(5);
    dx_ready = 1'b1;
    grad_valid = 1'b1;
    grad_in = W'(-7);
    step();
    grad_valid = 1'b0;
    chk("s6_dx_neg7", int'($signed(dx_out)), -7);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
